dot_accumulate: RTL
===================

DOT_ACCUMULATE -- requirements
Module: dot_accumulate

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 21, meaning the signed width of one product-sum term.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, meaning the signed accumulator and result width; legal only if ACC_WIDTH >= IN_WIDTH.
REQ-003 SHALL have parameter VEC_LEN, default 8, meaning the terms per dot product; legal range 2..65535.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: global clock-enable; when low, all state freezes.
REQ-007 SHALL have port clear, input, 1 bit: synchronous abort of the partial vector.
REQ-008 SHALL have port inReady, input, 1 bit: IN is valid this cycle.
REQ-009 SHALL have port IN, input, IN_WIDTH bits, signed: the term from the upstream multiply-add stage.
REQ-010 SHALL have port outReady, output, 1 bit: one-cycle pulse marking a valid RES.
REQ-011 SHALL have port RES, output, ACC_WIDTH bits, signed: the completed dot product.
REQ-012 SHALL have port overflow, output, 1 bit: RES of the current pulse overflowed ACC_WIDTH.
REQ-013 SHALL have port busy, output, 1 bit: a partial vector is held (count != 0).
REQ-014 SHALL have port count, output, $clog2(VEC_LEN) bits: number of terms accepted in the current vector.

Function
REQ-015 SHALL update state only on clk edges with enable=1; with enable=0, outReady, RES, count and acc hold unchanged.
REQ-016 SHALL sign-extend IN to ACC_WIDTH before any addition.
REQ-017 SHALL, on an accepted term (enable & inReady): if count=0, load acc := IN; otherwise acc := acc + IN. In both cases count increments.
REQ-018 SHALL, when the accepted term has count=VEC_LEN-1, load RES with the final sum, pulse outReady on the next cycle (latency 1 cycle after the last term), wrap count to 0 and free acc.
REQ-019 SHALL hold RES between pulses; outReady SHALL be high for exactly one enabled cycle per completed vector.
REQ-020 SHALL accept a new vector's first term in the same cycle that outReady is high, with no bubble.
REQ-021 SHALL, on clear=1 with enable=1: set count to 0, discard acc, and leave RES unchanged. If inReady is also high, clear SHALL act first and IN SHALL be taken as term 0 of a new vector.
REQ-022 SHALL set an internal sticky overflow bit when any addition in the vector overflows signed ACC_WIDTH; the bit SHALL clear at vector start and be presented on overflow alongside the outReady pulse.
REQ-023 SHALL ignore inReady when enable=0; an upstream pulse lost this way is the upstream block's responsibility.

Reset
REQ-024 SHALL, while reset=0, asynchronously force outReady=0, RES=0, overflow=0, count=0, busy=0 and acc=0.
REQ-025 SHALL, on reset mid-vector, discard the partial vector and produce no outReady pulse for it.

Configuration
REQ-026 SHALL use the macro DOT_ACCUMULATE_SAT_EN: when defined, an overflowing addition saturates acc to the signed ACC_WIDTH max or min; when undefined, acc wraps modulo 2^ACC_WIDTH. The overflow flag SHALL behave identically in both builds.

Structure
REQ-027 SHALL place the width helper functions and the shared VEC_LEN/ACC_WIDTH defaults in package linalg_pkg.
REQ-028 SHALL implement the add-with-overflow-detect (and optional saturation) as sub-module dot_acc_add.
REQ-029 SHALL be 120-400 lines of RTL with no memories; registers only.

Verification (VEC_LEN=4, IN_WIDTH=21, ACC_WIDTH=32)
REQ-030 SHALL cover: terms 1, 2, 3, 4 on consecutive cycles -> outReady pulses one cycle after term 4 with RES=10 and overflow=0.
REQ-031 SHALL cover: terms -5, 7 with enable low for 3 cycles, then 1, 1 -> RES=4, the pulse arrives one enabled cycle later, and count holds at 2 while enable is low.
REQ-032 SHALL cover: two vectors back to back (1,1,1,1 then 2,2,2,2 with no gap) -> RES=4 then RES=8, each pulse a single cycle, and the second vector's term 0 accepted during the first pulse.
REQ-033 SHALL cover: terms 9, 9, then clear together with inReady and IN=5, followed by 5, 5, 5 -> RES=20, and the earlier RES is held until that pulse.
REQ-034 SHALL cover: four terms of 2^20-1 with ACC_WIDTH=22 -> overflow=1; RES=2^21-1 with DOT_ACCUMULATE_SAT_EN defined, and the wrapped value without it.
REQ-035 SHALL cover: reset asserted after 2 terms -> all outputs 0 immediately and no outReady pulse; the next 4 terms of 3 give RES=12.

Source files
------------

// File: rtl/linalg_pkg.sv
// Shared defaults and width helpers for the linear-algebra datapath blocks.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package linalg_pkg;

    localparam int DEF_IN_WIDTH  = 21;
    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_VEC_LEN   = 8;

    // Counter width for 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit widths_legal(input int in_w, input int acc_w);
        return acc_w >= in_w;
    endfunction

endpackage

// File: rtl/dot_acc_add.sv
// Signed adder with two's-complement overflow detect; saturates under DOT_ACCUMULATE_SAT_EN.
// Latency: combinational.
// Backpressure: none.
module dot_acc_add #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    ovf
);

    logic signed [WIDTH-1:0] raw_sum;

    assign raw_sum = a + b;

    // Overflow only when both operands share a sign the result lacks.
    assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw_sum[WIDTH-1] != a[WIDTH-1]);

`ifdef DOT_ACCUMULATE_SAT_EN
    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        sum = raw_sum;
        if (ovf) begin
            sum = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum = raw_sum;
`endif

endmodule

// File: rtl/dot_accumulate.sv
// Accumulates VEC_LEN signed terms into one dot product; DOT_ACCUMULATE_SAT_EN selects saturating adds.
// Latency: RES/outReady one cycle after the last term; next vector may start on the pulse cycle.
// Backpressure: none; enable freezes all state and terms offered while it is low are dropped.
module dot_accumulate
    import linalg_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int VEC_LEN   = DEF_VEC_LEN
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                clear,
    input  logic                                inReady,
    input  logic signed [IN_WIDTH-1:0]          IN,
    output logic                                outReady,
    output logic signed [ACC_WIDTH-1:0]         RES,
    output logic                                overflow,
    output logic                                busy,
    output logic [cnt_width(VEC_LEN)-1:0]       count
);

    localparam int            CW   = cnt_width(VEC_LEN);
    localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

    // Elaboration fails on an unresolvable instance if the widths are illegal.
    generate
        if (!widths_legal(IN_WIDTH, ACC_WIDTH)) begin : g_bad_widths
            dot_accumulate_acc_width_below_in_width u_bad_widths ();
        end
    endgenerate

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] in_ext;
    logic signed [ACC_WIDTH-1:0] add_sum;
    logic                        add_ovf;
    logic                        ovf_sticky;
    logic [CW-1:0]               cnt_eff;
    logic                        first_term;
    logic                        last_term;

    assign in_ext = ACC_WIDTH'(IN);

    // clear takes effect before a same-cycle term, so that term becomes term 0.
    assign cnt_eff    = clear ? '0 : count;
    assign first_term = (cnt_eff == '0);
    assign last_term  = (cnt_eff == LAST);

    dot_acc_add #(
        .WIDTH (ACC_WIDTH)
    ) u_add (
        .a   (acc),
        .b   (in_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outReady   <= 1'b0;
            RES        <= '0;
            overflow   <= 1'b0;
            count      <= '0;
            acc        <= '0;
            ovf_sticky <= 1'b0;
        end else if (enable) begin
            outReady <= 1'b0;
            if (inReady) begin
                if (last_term) begin
                    RES        <= first_term ? in_ext : add_sum;
                    overflow   <= first_term ? 1'b0 : (ovf_sticky | add_ovf);
                    outReady   <= 1'b1;
                    count      <= '0;
                    acc        <= '0;
                    ovf_sticky <= 1'b0;
                end else begin
                    acc        <= first_term ? in_ext : add_sum;
                    ovf_sticky <= first_term ? 1'b0 : (ovf_sticky | add_ovf);
                    count      <= cnt_eff + CW'(1);
                end
            end else if (clear) begin
                count      <= '0;
                acc        <= '0;
                ovf_sticky <= 1'b0;
            end
        end
    end

    assign busy = (count != '0);

endmodule
